// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: fetch PC, ROM index, fetch FIFO to decode
// Halts on an all-zero word (end of image); redirects flush the buffer and re-align the target.
module if_fetch_stage #(
  parameter int                PC_LEN     = 64,
  parameter int                INSTR_LEN  = 32,
  parameter logic [PC_LEN-1:0] RST_PC     = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PC_LEN-1:0]    rom_idx_o,
  input  logic [INSTR_LEN-1:0] rom_data_i,
  input  logic                 redirect_valid_i,
  input  logic [PC_LEN-1:0]    redirect_pc_i,
  output logic                 id_valid_o,
  input  logic                 id_ready_i,
  output logic [PC_LEN-1:0]    id_pc_o,
  output logic [INSTR_LEN-1:0] id_instr_o,
  output logic                 halt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_LEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PC_LEN-1:0]    pc_mem_q    [FIFO_DEPTH];
  logic [INSTR_LEN-1:0] instr_mem_q [FIFO_DEPTH];

  logic pop;
  logic push;
  logic zero_word;

  assign pop       = (count_q != '0) & id_ready_i;
  assign zero_word = (rom_data_i == '0);
  assign push      = (state_q == RUN) & ~redirect_valid_i & ~zero_word &
                     ((count_q < DEPTH_C) | pop);

  // Redirect wins over both push and halt detection; a pop in the same cycle still counts for decode.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid_i) begin
      state_d    = RUN;
      fetch_pc_d = {redirect_pc_i[PC_LEN-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if ((state_q == RUN) && zero_word) begin
        state_d = HALT;
      end
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PC_LEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RST_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= rom_data_i;
    end
  end

  // Head fields come straight from storage, never from rom_data_i.
  assign rom_idx_o  = fetch_pc_q;
  assign id_valid_o = (count_q != '0);
  assign id_pc_o    = pc_mem_q[rd_ptr_q];
  assign id_instr_o = instr_mem_q[rd_ptr_q];
  assign halt_o     = (state_q == HALT);

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV64IM core; sits directly upstream of the instruction ROM and downstream-feeds decode.
- Holds the fetch PC and drives it as the ROM index. The ROM read is combinational; the returned word is captured in a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects from branches and jumps, and halts fetch on an all-zero word, which marks the end of the program image.

Parameters:
- PC_LEN, 64, width of PC and ROM index.
- INSTR_LEN, 32, instruction width.
- RST_PC, 64'h0000_0000_0000_0000, fetch PC after reset; must match the ROM base index.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, ≥2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rom_idx_o  out  PC_LEN  fetch address to the ROM; equals the fetch_pc register.
- rom_data_i  in  INSTR_LEN  ROM read data for rom_idx_o, valid in the same cycle.
- redirect_valid_i  in  1  redirect request from execute.
- redirect_pc_i  in  PC_LEN  redirect target.
- id_valid_o  out  1  FIFO head is valid.
- id_ready_i  in  1  decode accepts the head.
- id_pc_o  out  PC_LEN  PC of the head entry.
- id_instr_o  out  INSTR_LEN  instruction of the head entry.
- halt_o  out  1  fetch has stopped on a zero word.

Behaviour:
- Reset (rst_n=0, async):
  - fetch_pc=RST_PC, FIFO count=0, rd_ptr=wr_ptr=0, all entries cleared to 0.
  - state=RUN.
  - Outputs: id_valid_o=0, id_pc_o=0, id_instr_o=0, halt_o=0, rom_idx_o=RST_PC.
  - Mid-operation reset discards all buffered entries immediately.
- Derived signals:
  - pop = id_valid_o & id_ready_i.
  - zero_word = (rom_data_i == 0).
  - push = state==RUN & !redirect_valid_i & !zero_word & (count<FIFO_DEPTH | pop).
- Push:
  - Write {fetch_pc, rom_data_i} at wr_ptr, advance wr_ptr, and set fetch_pc += 4.
  - PC arithmetic is modulo 2^PC_LEN, so it wraps silently.
- Pop: advance rd_ptr.
- Count update: count += push − pop. Simultaneous push and pop when full is legal and leaves count unchanged.
- Output path:
  - id_valid_o = (count != 0).
  - id_pc_o and id_instr_o are read from entry[rd_ptr], i.e. register-sourced, with no combinational path from rom_data_i.
  - Head fields remain stable while id_valid_o=1 and id_ready_i=0.
- Fetch latency: a word fetched in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle when decode is always ready.
- State machine (RUN, HALT):
  - RUN → HALT when state==RUN & !redirect_valid_i & zero_word. The zero word is not pushed and fetch_pc holds.
  - HALT: no pushes and fetch_pc holds. Already-buffered entries continue to drain normally. halt_o = (state==HALT).
  - HALT → RUN on redirect_valid_i.
- Redirect (highest priority over push and halt detection):
  - On the edge with redirect_valid_i=1: count=0, rd_ptr=wr_ptr=0, state=RUN.
  - fetch_pc = {redirect_pc_i[PC_LEN-1:2], 2'b00}; targets are forced to 4-byte alignment.
  - The pop that cycle is still taken by decode, but the flushed entries are discarded.
  - The first new instruction is at the head on the cycle after next.
- Full with no pop: fetch_pc holds and rom_idx_o is unchanged, so the word is refetched later.

Test Plan:
- Reset with RST_PC=0, id_ready_i=1, ROM words 0x00100093, 0x00100113, 0x00118013 → head pc 0, 4, 8 on consecutive cycles with the matching instrs; id_valid_o first high on cycle 1 after reset release.
- id_ready_i=0 for 5 cycles → count saturates at 2, rom_idx_o holds at 8, head stays pc 0 / 0x00100093; release ready → pcs 0, 4, 8 delivered with no gap, loss or duplicate.
- Redirect to 0x2A in the same cycle a push would occur → FIFO flushed, no push; rom_idx_o=0x28 next cycle; head becomes pc 0x28 two cycles after the redirect.
- ROM returns 0 at pc 0x6C → halt_o=1 next cycle, rom_idx_o stuck at 0x6C, remaining entries drain, id_valid_o falls to 0; redirect to 0x10 → halt_o=0, fetch resumes at 0x10.
- Full FIFO with a simultaneous pop and push for 10 cycles at ready=1 → count stays 2, pcs strictly +4 in order.
- Assert rst_n low with 2 entries buffered → id_valid_o=0 and rom_idx_o=RST_PC asynchronously, before the next clock edge.
